// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer: opcodes,
// one-hot ALU select encodings, FSM state codes and the opcode decoder.
package alu_seq_pkg;

  // Opcode as it arrives on in_op and leaves on out_op.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_NEGA = 3'd1,
    OP_NEGB = 3'd2,
    OP_SUB  = 3'd3,
    OP_MUL  = 3'd4,
    OP_AND  = 3'd5,
    OP_OR   = 3'd6,
    OP_XOR  = 3'd7
  } opcode_t;

  // One-hot select lines of the combinational ALU (MSB = ADD).
  localparam logic [7:0] SEL_NONE = 8'h00;
  localparam logic [7:0] SEL_ADD  = 8'h80;
  localparam logic [7:0] SEL_NEGA = 8'h40;
  localparam logic [7:0] SEL_NEGB = 8'h20;
  localparam logic [7:0] SEL_SUB  = 8'h10;
  localparam logic [7:0] SEL_MUL  = 8'h08;
  localparam logic [7:0] SEL_AND  = 8'h04;
  localparam logic [7:0] SEL_OR   = 8'h02;
  localparam logic [7:0] SEL_XOR  = 8'h01;

  // FSM state codes. ST_MUL_ITER is only reachable in the iterative build.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_EXEC     = 2'd1;
  localparam state_t ST_MUL_ITER = 2'd2;
  localparam state_t ST_DONE     = 2'd3;

  // Map an opcode to the ALU one-hot select.
  function automatic logic [7:0] op_to_sel(input opcode_t op);
    logic [7:0] sel;
    case (op)
      OP_ADD:  sel = SEL_ADD;
      OP_NEGA: sel = SEL_NEGA;
      OP_NEGB: sel = SEL_NEGB;
      OP_SUB:  sel = SEL_SUB;
      OP_MUL:  sel = SEL_MUL;
      OP_AND:  sel = SEL_AND;
      OP_OR:   sel = SEL_OR;
      OP_XOR:  sel = SEL_XOR;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_seq_iter_mul.sv
// Shift-add multiplier used by alu_op_sequencer when ITER_MUL_EN is defined.
// One partial product per cycle over DATA_W cycles. 'start' clears the
// accumulator and counter; 'done' flags the last cycle, during which
// 'result' already includes the final partial product.
module alu_seq_iter_mul #(
  parameter  int DATA_W = 4,
  localparam int RES_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              active,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [RES_W-1:0]  result
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] partial;

  // Partial product for the current bit of b, and the running sum including it.
  always_comb begin
    partial = b[cnt_q] ? (RES_W'(a) << cnt_q) : '0;
    result  = acc_q + partial;
    done    = active && (cnt_q == CNT_LAST);
  end

  // Accumulator/counter next-state: clear on start, step while active.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (active) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        acc_d = result;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Accumulator and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response controller in front of the combinational ALU datapath.
// Accepts one op per in_valid/in_ready handshake, holds the operands on
// alu_a/alu_b, pulses the one-hot alu_sel for the single EXEC cycle,
// registers the ALU result and offers it on out_valid/out_ready.
// Optional build macro ITER_MUL_EN: MUL is computed by an internal
// shift-add unit over DATA_W cycles instead of the ALU multiplier.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int DATA_W = 4,
  localparam int RES_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic [2:0]        out_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_sel,
  input  logic [RES_W-1:0]  alu_result,
  output logic              busy
);

  state_t            state_q, state_d;
  opcode_t           op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              out_valid_q, out_valid_d;
  logic [RES_W-1:0]  out_result_q, out_result_d;
  opcode_t           out_op_q, out_op_d;

  logic              accept;
  state_t            entry_state;

`ifdef ITER_MUL_EN
  logic              mul_start;
  logic              mul_active;
  logic              mul_done;
  logic [RES_W-1:0]  mul_result;

  // Iterative multiplier starts on the accepting edge of a MUL.
  always_comb begin
    mul_start  = accept && (in_op == OP_MUL);
    mul_active = (state_q == ST_MUL_ITER);
  end

  alu_seq_iter_mul #(
    .DATA_W (DATA_W)
  ) u_iter_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .active (mul_active),
    .a      (a_q),
    .b      (b_q),
    .done   (mul_done),
    .result (mul_result)
  );
`endif

  // Handshake: a new op is taken when idle, or when the pending result is
  // consumed on the same edge, giving one op every two cycles.
  always_comb begin
    in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    accept   = in_valid && in_ready;
  end

  // State entered from an accepted request.
  always_comb begin
`ifdef ITER_MUL_EN
    entry_state = (in_op == OP_MUL) ? ST_MUL_ITER : ST_EXEC;
`else
    entry_state = ST_EXEC;
`endif
  end

  // Main FSM and datapath register next-state logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = opcode_t'(in_op);
          a_d     = in_a;
          b_d     = in_b;
          state_d = entry_state;
        end
      end

      ST_EXEC: begin
        // ALU output is taken verbatim; the controller does not interpret it.
        out_result_d = alu_result;
        out_op_d     = op_q;
        out_valid_d  = 1'b1;
        state_d      = ST_DONE;
      end

`ifdef ITER_MUL_EN
      ST_MUL_ITER: begin
        if (mul_done) begin
          out_result_d = mul_result;
          out_op_d     = op_q;
          out_valid_d  = 1'b1;
          state_d      = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        // Result and opcode stay frozen until the consumer takes them.
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            op_d    = opcode_t'(in_op);
            a_d     = in_a;
            b_d     = in_b;
            state_d = entry_state;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Controller registers; reset discards any in-flight op or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and result registers are reset too, so alu_a/alu_b and
      // out_result present known values straight out of reset.
      state_q      <= ST_IDLE;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_op_q     <= OP_ADD;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
    end
  end

  // Output drive: operands straight from flops; select only during EXEC.
  always_comb begin
    alu_a      = a_q;
    alu_b      = b_q;
    alu_sel    = (state_q == ST_EXEC) ? op_to_sel(op_q) : SEL_NONE;
    out_valid  = out_valid_q;
    out_result = out_result_q;
    out_op     = out_op_q;
    busy       = (state_q != ST_IDLE);
  end

endmodule
